// File: rtl/acc_ctrl.sv
// acc_ctrl: multi-cycle fetch/decode control unit that drives accumulator, register-file and ALU controls.
module acc_ctrl #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            CLB,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    input  logic            acc_zero,
    output logic            loadAcc,
    output logic [1:0]      sel_acc,
    output logic [3:0]      imm,
    output logic [3:0]      reg_sel,
    output logic            reg_we,
    output logic [2:0]      alu_op,
    output logic [PC_W-1:0] pc,
    output logic            halted
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WRITE, HALT} state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [7:0]      ir_q;
    logic            req_q, load_acc_q, reg_we_q, halted_q;
    logic [1:0]      sel_acc_q;
    logic [3:0]      imm_q, reg_sel_q;
    logic [2:0]      alu_op_q;
    logic [3:0]      opc, opr;

    assign opc       = ir_q[7:4];
    assign opr       = ir_q[3:0];
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign loadAcc   = load_acc_q;
    assign reg_we    = reg_we_q;
    assign sel_acc   = sel_acc_q;
    assign imm       = imm_q;
    assign reg_sel   = reg_sel_q;
    assign alu_op    = alu_op_q;
    assign halted    = halted_q;

    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            req_q      <= 1'b0;
            load_acc_q <= 1'b0;
            reg_we_q   <= 1'b0;
            halted_q   <= 1'b0;
            sel_acc_q  <= '0;
            imm_q      <= '0;
            reg_sel_q  <= '0;
            alu_op_q   <= '0;
        end else begin
            // strobes are single-cycle unless a state re-asserts them
            load_acc_q <= 1'b0;
            reg_we_q   <= 1'b0;
            case (state_q)
                IDLE: if (run) begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: if (imem_ack) begin
                    ir_q    <= imem_data;
                    pc_q    <= pc_q + 1'b1;
                    req_q   <= 1'b0;
                    state_q <= DECODE;
                end
                DECODE: if (opc == 4'hF) begin
                    state_q  <= HALT;
                    halted_q <= 1'b1;
                end else if (opc == 4'h0 || opc >= 4'hA) begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    if (opc == 4'hA || (opc == 4'hB && acc_zero))
                        pc_q <= PC_W'(opr);
                end else begin
                    state_q   <= EXEC;
                    sel_acc_q <= opc == 4'h1 ? 2'b11 : opc == 4'h2 ? 2'b10 : 2'b00;
                    imm_q     <= opc == 4'h1 ? opr : 4'h0;
                    reg_sel_q <= opc == 4'h1 ? 4'h0 : opr;
                    alu_op_q  <= opc >= 4'h4 ? 3'(opc - 4'd4) : 3'd0;
                    reg_we_q  <= opc == 4'h3;
                end
                EXEC: if (opc == 4'h3) begin
                    state_q   <= FETCH;
                    req_q     <= 1'b1;
                    sel_acc_q <= '0;
                    imm_q     <= '0;
                    reg_sel_q <= '0;
                    alu_op_q  <= '0;
                end else begin
                    state_q    <= WRITE;
                    load_acc_q <= 1'b1;
                end
                WRITE: begin
                    state_q   <= FETCH;
                    req_q     <= 1'b1;
                    sel_acc_q <= '0;
                    imm_q     <= '0;
                    reg_sel_q <= '0;
                    alu_op_q  <= '0;
                end
                HALT: ;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_ctrl.sv
// tb_acc_ctrl: ISA-level reference model feeding an expected-event scoreboard checked by a monitor.
module tb_acc_ctrl;
    logic       clk = 1'b0, CLB, run, imem_req, imem_ack, acc_zero, loadAcc, reg_we, halted;
    logic [3:0] imem_addr, pc, imm, reg_sel;
    logic [7:0] imem_data;
    logic [1:0] sel_acc;
    logic [2:0] alu_op;

    acc_ctrl #(.PC_W(4)) dut (
        .clk(clk), .CLB(CLB), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .acc_zero(acc_zero), .loadAcc(loadAcc),
        .sel_acc(sel_acc), .imm(imm), .reg_sel(reg_sel), .reg_we(reg_we), .alu_op(alu_op),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    // kinds: 0 fetch (addr), 1 accumulator load (sel/imm/reg_sel/alu_op), 2 register write (reg_sel), 3 halt (pc)
    typedef struct {
        int          kind;
        logic [15:0] val;
        logic [15:0] mask;
        int          dcyc;
    } ev_t;

    ev_t         q[$];
    logic [7:0]  mem[16];
    int          chk_cnt = 0, pass_cnt = 0, cyc = 0, last_f = 0;
    logic [15:0] prev_sel = '0;
    logic        h_prev = 1'b0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    endfunction

    task automatic push_ev(input int k, input logic [15:0] v, input logic [15:0] m, input int dc);
        ev_t e;
        e.kind = k; e.val = v; e.mask = m; e.dcyc = dc;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input int k, input logic [15:0] v);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_event", k, 32'hFF);
            return;
        end
        e = q.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_value", v & e.mask, e.val & e.mask);
        if (k == 1) chk("sel_held_exec", prev_sel & e.mask, e.val & e.mask);
        if (e.dcyc >= 0) chk("event_latency", cyc - last_f, e.dcyc);
        if (k == 0) last_f = cyc;
    endtask

    always @(negedge clk) begin
        logic [15:0] sel_now;
        cyc++;
        sel_now = {3'b0, sel_acc, imm, reg_sel, alu_op};
        if (!CLB) begin
            if (loadAcc || reg_we) chk("strobe_exclusive", {31'b0, loadAcc && reg_we}, 0);
            if (imem_req && imem_ack) pop_cmp(0, {12'b0, imem_addr});
            if (loadAcc) pop_cmp(1, sel_now);
            if (reg_we) pop_cmp(2, {12'b0, reg_sel});
            if (halted && !h_prev) pop_cmp(3, {12'b0, pc});
        end
        h_prev   = CLB ? 1'b0 : halted;
        prev_sel = sel_now;
    end

    // Memory responder plus ISA-level model; forces HLT once `limit` instructions were fetched.
    task automatic run_prog(input int limit);
        int         n = 0, prev_l = -1, d, to, l;
        logic [3:0] mpc = '0, op, o;
        logic [7:0] ins;
        logic       az, done = 1'b0;
        while (!done) begin
            if (n >= limit) mem[mpc] = 8'hF0;
            ins = mem[mpc];
            d   = $urandom_range(0, 3);
            az  = 1'($urandom_range(0, 1));
            push_ev(0, {12'b0, mpc}, 16'h000F, prev_l < 0 ? -1 : prev_l + d);
            to = 0;
            while (!imem_req && to < 20) begin
                @(posedge clk); #1; to++;
            end
            if (!imem_req) begin
                chk("fetch_req_timeout", 0, 1);
                return;
            end
            repeat (d) begin
                chk("stall_addr", imem_addr, mpc);
                chk("stall_req", imem_req, 1);
                @(posedge clk); #1;
            end
            imem_data = mem[imem_addr];
            imem_ack  = 1'b1;
            acc_zero  = az;
            mpc++;
            n++;
            op = ins[7:4];
            o  = ins[3:0];
            l  = 2;
            if (op == 4'h1) begin
                push_ev(1, {3'b0, 2'b11, o, 4'h0, 3'h0}, {3'b0, 2'b11, 4'hF, 4'h0, 3'h0}, 3); l = 4;
            end else if (op == 4'h2) begin
                push_ev(1, {3'b0, 2'b10, 4'h0, o, 3'h0}, {3'b0, 2'b11, 4'h0, 4'hF, 3'h0}, 3); l = 4;
            end else if (op == 4'h3) begin
                push_ev(2, {12'b0, o}, 16'h000F, 2); l = 3;
            end else if (op >= 4'h4 && op <= 4'h9) begin
                push_ev(1, {3'b0, 2'b00, 4'h0, o, 3'(op - 4'd4)},
                        {3'b0, 2'b11, 4'h0, (op == 4'h9) ? 4'h0 : 4'hF, 3'h7}, 3); l = 4;
            end else if (op == 4'hA || (op == 4'hB && az)) begin
                mpc = o;
            end else if (op == 4'hF) begin
                push_ev(3, {12'b0, mpc}, 16'h000F, 2); done = 1'b1;
            end
            prev_l = l;
            @(posedge clk); #1;
            imem_ack  = 1'b0;
            imem_data = 8'($urandom);
        end
    endtask

    task automatic do_prog(input int limit);
        int to = 0;
        CLB = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        q.delete();
        CLB = 1'b0; run = 1'b1;
        @(posedge clk); #1;
        run_prog(limit);
        while (q.size() != 0 && to < 10) begin
            @(posedge clk); #1; to++;
        end
        chk("scoreboard_drained", q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("halt_stays", halted, 1);
        chk("halt_no_req", imem_req, 0);
    endtask

    initial begin
        CLB = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = '0; acc_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1 CLB = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_req", imem_req, 0);
        chk("idle_pc", pc, 0);
        chk("idle_load", loadAcc, 0);
        chk("idle_we", reg_we, 0);
        chk("idle_sel", {sel_acc, imm, reg_sel, alu_op}, 0);
        chk("idle_halted", halted, 0);
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, 0);
        #2 CLB = 1'b1;
        #1;
        chk("async_reset_req", imem_req, 0);
        chk("async_reset_pc", pc, 0);
        repeat (2) @(posedge clk);
        #1 CLB = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stay_idle_req", imem_req, 0);

        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'h15; mem[1] = 8'h43; mem[2] = 8'hF0;
        do_prog(100);
        chk("halt_pc", pc, 3);

        for (int r = 0; r < 4; r++) begin
            foreach (mem[i]) mem[i] = 8'h00;
            mem[0] = 8'h37; mem[1] = 8'hB9; mem[2] = 8'h25; mem[3] = 8'h62; mem[4] = 8'h90;
            mem[5] = 8'hF0; mem[9] = 8'h71; mem[10] = 8'h84; mem[11] = 8'h5C; mem[12] = 8'hD3;
            mem[13] = 8'h0F; mem[14] = 8'hF0;
            do_prog(100);
        end

        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'hAF;
        do_prog(2);

        for (int r = 0; r < 6; r++) begin
            foreach (mem[i]) mem[i] = 8'($urandom);
            do_prog(30);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
